// File: rtl/adder_tree_feeder.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_feeder
// Brief    : Packs NUM_INPUTS serial samples into one vector for the adder
//            tree and flags the cycle in which the tree's sum is valid.
//            Optional macro ADDER_TREE_FEEDER_SHORT_FRAME_EN enables i_last.
// Revision : 1.0  initial release
// ============================================================================
module adder_tree_feeder #(
    parameter int NUM_INPUTS = 16,
    parameter int DWIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [DWIDTH-1:0]            i_dat,
    input  logic                         i_last,
    output logic                         o_ready,
    output logic [NUM_INPUTS*DWIDTH-1:0] o_vec,
    output logic                         o_vec_valid,
    input  logic                         i_vec_ready,
    output logic                         o_sum_valid
);

    localparam int NUM_STAGES = $clog2(NUM_INPUTS);
    localparam int CW         = NUM_STAGES + 1;
    localparam int VW         = NUM_INPUTS * DWIDTH;

    localparam logic [CW-1:0] c_LAST = CW'(NUM_INPUTS - 1);
    localparam logic [CW-1:0] c_FULL = CW'(NUM_INPUTS);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [VW-1:0]           fill_q, fill_d;
    logic [VW-1:0]           vec_q, vec_d;
    logic                    vec_valid_q, vec_valid_d;
    logic [NUM_STAGES-1:0]   pipe_q, pipe_d;

    logic                    w_accept;
    logic                    w_load_ok;
    logic                    w_hs;
    logic                    w_frame_end;
    logic [NUM_STAGES-1:0]   w_idx;
    logic [VW-1:0]           w_merged;

    assign o_ready     = (state_q == ST_FILL);
    assign o_vec       = vec_q;
    assign o_vec_valid = vec_valid_q;
    assign o_sum_valid = pipe_q[NUM_STAGES-1];

    assign w_accept  = i_valid & o_ready;
    assign w_load_ok = ~vec_valid_q | i_vec_ready;
    assign w_hs      = vec_valid_q & i_vec_ready;
    assign w_idx     = count_q[NUM_STAGES-1:0];

`ifdef ADDER_TREE_FEEDER_SHORT_FRAME_EN
    assign w_frame_end = (count_q == c_LAST) | i_last;
`else
    assign w_frame_end = (count_q == c_LAST);
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    // Fill register with the incoming sample dropped into its slot.
    always_comb begin
        w_merged = fill_q;
        w_merged[int'(w_idx)*DWIDTH +: DWIDTH] = i_dat;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fill_d      = fill_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q & ~i_vec_ready;
        case (state_q)
            ST_FILL: begin
                if (w_accept) begin
                    if (w_frame_end) begin
                        if (w_load_ok) begin
                            vec_d       = w_merged;
                            vec_valid_d = 1'b1;
                            count_d     = '0;
                            fill_d      = '0;
                        end else begin
                            fill_d  = w_merged;
                            count_d = c_FULL;
                            state_d = ST_FULL;
                        end
                    end else begin
                        fill_d  = w_merged;
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (w_load_ok) begin
                    vec_d       = fill_q;
                    vec_valid_d = 1'b1;
                    count_d     = '0;
                    fill_d      = '0;
                    state_d     = ST_FILL;
                end
            end
        endcase
    end

    // One bit per tree stage: a handshake emerges as o_sum_valid NUM_STAGES cycles later.
    generate
        if (NUM_STAGES == 1) begin : g_pipe_single
            assign pipe_d = w_hs;
        end else begin : g_pipe_multi
            assign pipe_d = {pipe_q[NUM_STAGES-2:0], w_hs};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            count_q     <= '0;
            fill_q      <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            pipe_q      <= pipe_d;
        end
    end

endmodule
`default_nettype wire
